// File: rtl/weight_bank_sequencer.sv
// Streams NUM_BANKS weight banks out as ready/valid beats, zero-padding the tail of the last bank.
// Optional macro WEIGHT_SEQ_MANUAL_SEL_EN adds manual_i/sel_i for single-bank transfers.
module weight_bank_sequencer #(
    parameter int WEIGHT_W   = 8,
    parameter int LANES      = 62,
    parameter int NUM_BANKS  = 4,
    parameter int LAST_LANES = 30,
    localparam int BANK_W    = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
`ifdef WEIGHT_SEQ_MANUAL_SEL_EN
    input  logic                                   manual_i,
    input  logic [BANK_W-1:0]                      sel_i,
`endif
    input  logic [NUM_BANKS*LANES*WEIGHT_W-1:0]    bank_i,
    input  logic                                   start_i,
    input  logic                                   abort_i,
    input  logic                                   ready_i,
    output logic [LANES*WEIGHT_W-1:0]              weight_o,
    output logic                                   valid_o,
    output logic [BANK_W-1:0]                      bank_o,
    output logic                                   last_o,
    output logic                                   busy_o,
    output logic                                   done_o
);

    localparam int BEAT_W = LANES * WEIGHT_W;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [BEAT_W-1:0]   r_weight;
    logic                r_valid;
    logic                w_nextValid;
    logic [BANK_W-1:0]   r_bank;
    logic [BANK_W-1:0]   w_nextBank;
    logic                r_done;
    logic                w_nextDone;
    logic                r_manual;
    logic                w_nextManual;
    logic                w_load;
    logic [BANK_W-1:0]   w_loadIdx;
    logic [BEAT_W-1:0]   w_loadData;
    logic                w_manualStart;
    logic [BANK_W-1:0]   w_sel;
    logic [BANK_W-1:0]   w_selBank;

`ifdef WEIGHT_SEQ_MANUAL_SEL_EN
    assign w_manualStart = manual_i;
    assign w_sel         = sel_i;
`else
    assign w_manualStart = 1'b0;
    assign w_sel         = '0;
`endif

    // Out-of-range selects report as the last bank but carry all-zero data.
    assign w_selBank = (int'(w_sel) >= NUM_BANKS) ? LAST_BANK : w_sel;

    always_comb begin
        w_loadData = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(w_loadIdx) == b) begin
                w_loadData = bank_i[b*BEAT_W +: BEAT_W];
            end
        end
        if (w_loadIdx == LAST_BANK) begin
            for (int l = LAST_LANES; l < LANES; l++) begin
                w_loadData[l*WEIGHT_W +: WEIGHT_W] = '0;
            end
        end
    end

    // Abort overrides everything, including a transfer or start on the same edge.
    always_comb begin
        w_nextState  = r_state;
        w_nextValid  = r_valid;
        w_nextBank   = r_bank;
        w_nextDone   = 1'b0;
        w_nextManual = r_manual;
        w_load       = 1'b0;
        w_loadIdx    = '0;
        if (abort_i) begin
            w_nextState  = IDLE;
            w_nextValid  = 1'b0;
            w_nextBank   = '0;
            w_nextManual = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        w_load       = 1'b1;
                        w_loadIdx    = w_manualStart ? w_sel : '0;
                        w_nextBank   = w_manualStart ? w_selBank : '0;
                        w_nextValid  = 1'b1;
                        w_nextManual = w_manualStart;
                        w_nextState  = SEND;
                    end
                end
                SEND: begin
                    if (ready_i) begin
                        if (r_bank == LAST_BANK || r_manual) begin
                            w_nextState  = IDLE;
                            w_nextValid  = 1'b0;
                            w_nextBank   = '0;
                            w_nextDone   = 1'b1;
                            w_nextManual = 1'b0;
                        end else begin
                            w_load     = 1'b1;
                            w_loadIdx  = r_bank + BANK_W'(1);
                            w_nextBank = r_bank + BANK_W'(1);
                        end
                    end
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextValid = 1'b0;
                    w_nextBank  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_weight <= '0;
            r_valid  <= 1'b0;
            r_bank   <= '0;
            r_done   <= 1'b0;
            r_manual <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_valid  <= w_nextValid;
            r_bank   <= w_nextBank;
            r_done   <= w_nextDone;
            r_manual <= w_nextManual;
            if (w_load) begin
                r_weight <= w_loadData;
            end
        end
    end

    assign weight_o = r_weight;
    assign valid_o  = r_valid;
    assign bank_o   = r_bank;
    assign last_o   = r_valid && (r_bank == LAST_BANK);
    assign busy_o   = (r_state == SEND);
    assign done_o   = r_done;

endmodule

// File: tb/tb_weight_bank_sequencer.sv
// Directed self-checking bench for weight_bank_sequencer at default parameters.
// Define WEIGHT_SEQ_MANUAL_SEL_EN to also exercise the manual bank-select path.
module tb_weight_bank_sequencer;

    localparam int WEIGHT_W = 8;
    localparam int LANES    = 62;
    localparam int NBANKS   = 4;
    localparam int LASTL    = 30;
    localparam int BEAT_W   = LANES * WEIGHT_W;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NBANKS*BEAT_W-1:0]    bank_i;
    logic                        start_i;
    logic                        abort_i;
    logic                        ready_i;
    logic [BEAT_W-1:0]           weight_o;
    logic                        valid_o;
    logic [1:0]                  bank_o;
    logic                        last_o;
    logic                        busy_o;
    logic                        done_o;
`ifdef WEIGHT_SEQ_MANUAL_SEL_EN
    logic                        manual_i;
    logic [1:0]                  sel_i;
`endif

    int checks = 0;
    int errors = 0;

    weight_bank_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef WEIGHT_SEQ_MANUAL_SEL_EN
        .manual_i (manual_i),
        .sel_i    (sel_i),
`endif
        .bank_i   (bank_i),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .ready_i  (ready_i),
        .weight_o (weight_o),
        .valid_o  (valid_o),
        .bank_o   (bank_o),
        .last_o   (last_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    // Every lane of bank b carries base+b, so the tail of bank 3 is nonzero at the input.
    task automatic setBanks(input logic [7:0] base);
        for (int b = 0; b < NBANKS; b++)
            for (int l = 0; l < LANES; l++)
                bank_i[b*BEAT_W + l*WEIGHT_W +: WEIGHT_W] = base + 8'(b);
    endtask

    function automatic logic [BEAT_W-1:0] expBeat(input int b, input logic [7:0] base);
        logic [BEAT_W-1:0] r;
        for (int l = 0; l < LANES; l++)
            r[l*WEIGHT_W +: WEIGHT_W] = (b == NBANKS-1 && l >= LASTL) ? 8'h00 : base + 8'(b);
        return r;
    endfunction

    task automatic test_reset();
        #2;
        checks++; if ({valid_o, bank_o, last_o, busy_o, done_o} !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl actual=%b expected=000000", {valid_o, bank_o, last_o, busy_o, done_o});
        end
        checks++; if (weight_o !== '0) begin
            errors++; $display("[TB] FAIL reset_weight actual=%h expected=0", weight_o);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_release_idle valid=%b busy=%b expected 0 0", valid_o, busy_o);
        end
    endtask

    task automatic test_full_sequence();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int b = 0; b < NBANKS; b++) begin
            checks++; if (valid_o !== 1'b1 || busy_o !== 1'b1) begin
                errors++; $display("[TB] FAIL seq_valid b=%0d valid=%b busy=%b expected 1 1", b, valid_o, busy_o);
            end
            checks++; if (bank_o !== 2'(b)) begin
                errors++; $display("[TB] FAIL seq_bank actual=%0d expected=%0d", bank_o, b);
            end
            checks++; if (last_o !== (b == NBANKS-1)) begin
                errors++; $display("[TB] FAIL seq_last b=%0d actual=%b expected=%b", b, last_o, b == NBANKS-1);
            end
            checks++; if (weight_o !== expBeat(b, 8'h10)) begin
                errors++; $display("[TB] FAIL seq_weight b=%0d actual=%h expected=%h", b, weight_o, expBeat(b, 8'h10));
            end
            if (b == NBANKS-1) begin
                checks++; if (weight_o[BEAT_W-1:LASTL*WEIGHT_W] !== '0 || weight_o[LASTL*WEIGHT_W-1 -: 8] !== 8'h13) begin
                    errors++; $display("[TB] FAIL seq_pad tail=%h lane29=%h expected 0 13", weight_o[BEAT_W-1:LASTL*WEIGHT_W], weight_o[LASTL*WEIGHT_W-1 -: 8]);
                end
            end
            @(negedge clk);
        end
        checks++; if (valid_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("[TB] FAIL seq_done valid=%b done=%b busy=%b expected 0 1 0", valid_o, done_o, busy_o);
        end
        @(negedge clk);
        checks++; if (done_o !== 1'b0) begin
            errors++; $display("[TB] FAIL seq_done_width actual=%b expected=0", done_o);
        end
    endtask

    task automatic test_backpressure();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        ready_i = 1'b0;
        setBanks(8'hA0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (valid_o !== 1'b1 || bank_o !== 2'd1 || weight_o !== expBeat(1, 8'h10)) begin
                errors++; $display("[TB] FAIL stall_hold i=%0d valid=%b bank=%0d weight=%h expected 1 1 %h", i, valid_o, bank_o, weight_o, expBeat(1, 8'h10));
            end
        end
        ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bank_o !== 2'd2 || weight_o !== expBeat(2, 8'hA0)) begin
            errors++; $display("[TB] FAIL stall_resume bank=%0d weight=%h expected 2 %h", bank_o, weight_o, expBeat(2, 8'hA0));
        end
        @(negedge clk);
        checks++; if (last_o !== 1'b1 || weight_o !== expBeat(3, 8'hA0)) begin
            errors++; $display("[TB] FAIL stall_last last=%b weight=%h expected 1 %h", last_o, weight_o, expBeat(3, 8'hA0));
        end
        @(negedge clk);
        checks++; if (done_o !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_done actual=%b expected=1", done_o);
        end
        setBanks(8'h10);
        @(negedge clk);
    endtask

    task automatic test_abort();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (bank_o !== 2'd2) begin
            errors++; $display("[TB] FAIL abort_setup bank actual=%0d expected=2", bank_o);
        end
        abort_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        checks++; if ({valid_o, busy_o, bank_o, done_o} !== 5'b0) begin
            errors++; $display("[TB] FAIL abort_idle actual=%b expected=00000", {valid_o, busy_o, bank_o, done_o});
        end
        @(negedge clk);
        checks++; if (done_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_no_done done=%b valid=%b expected 0 0", done_o, valid_o);
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || bank_o !== 2'd0 || weight_o !== expBeat(0, 8'h10)) begin
            errors++; $display("[TB] FAIL abort_restart valid=%b bank=%0d weight=%h", valid_o, bank_o, weight_o);
        end
        for (int i = 0; i < 5; i++) @(negedge clk);
    endtask

    task automatic test_async_reset();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({valid_o, bank_o, last_o, busy_o, done_o} !== 6'b0 || weight_o !== '0) begin
            errors++; $display("[TB] FAIL async_reset ctrl=%b weight=%h expected 000000 0", {valid_o, bank_o, last_o, busy_o, done_o}, weight_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (done_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++; $display("[TB] FAIL async_no_done i=%0d done=%b valid=%b expected 0 0", i, done_o, valid_o);
            end
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || bank_o !== 2'd0) begin
            errors++; $display("[TB] FAIL async_restart valid=%b bank=%0d expected 1 0", valid_o, bank_o);
        end
        for (int i = 0; i < 5; i++) @(negedge clk);
    endtask

    task automatic test_start_held();
        start_i = 1'b1;
        for (int b = 0; b < NBANKS; b++) begin
            @(negedge clk);
            checks++; if (valid_o !== 1'b1 || bank_o !== 2'(b)) begin
                errors++; $display("[TB] FAIL held_beat valid=%b bank=%0d expected 1 %0d", valid_o, bank_o, b);
            end
        end
        @(negedge clk);
        checks++; if (valid_o !== 1'b0 || done_o !== 1'b1) begin
            errors++; $display("[TB] FAIL held_done valid=%b done=%b expected 0 1", valid_o, done_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || bank_o !== 2'd0 || done_o !== 1'b0) begin
            errors++; $display("[TB] FAIL held_restart valid=%b bank=%0d done=%b expected 1 0 0", valid_o, bank_o, done_o);
        end
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++; if (done_o !== 1'b1) begin
            errors++; $display("[TB] FAIL held_second_done actual=%b expected=1", done_o);
        end
        @(negedge clk);
    endtask

`ifdef WEIGHT_SEQ_MANUAL_SEL_EN
    task automatic test_manual();
        for (int s = 2; s <= 3; s++) begin
            manual_i = 1'b1;
            sel_i    = 2'(s);
            start_i  = 1'b1;
            @(negedge clk);
            start_i  = 1'b0;
            manual_i = 1'b0;
            checks++; if (valid_o !== 1'b1 || bank_o !== 2'(s) || last_o !== (s == 3) || weight_o !== expBeat(s, 8'h10)) begin
                errors++; $display("[TB] FAIL manual_beat sel=%0d valid=%b bank=%0d last=%b weight=%h", s, valid_o, bank_o, last_o, weight_o);
            end
            @(negedge clk);
            checks++; if (valid_o !== 1'b0 || done_o !== 1'b1) begin
                errors++; $display("[TB] FAIL manual_done sel=%0d valid=%b done=%b expected 0 1", s, valid_o, done_o);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        ready_i = 1'b1;
`ifdef WEIGHT_SEQ_MANUAL_SEL_EN
        manual_i = 1'b0;
        sel_i    = '0;
`endif
        setBanks(8'h10);
        test_reset();
        test_full_sequence();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_start_held();
`ifdef WEIGHT_SEQ_MANUAL_SEL_EN
        test_manual();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
